// File: rtl/exec_alu_md.sv
// ---------------------------------------------------------------------------
// exec_alu_md
//   Execute-stage arithmetic unit for the MIPS datapath.
//   Single-cycle ops (logic, add/sub, shifts, compares) return a registered
//   result one cycle after issue. Unsigned multiply (shift-add) and divide
//   (restoring) iterate one bit per cycle over WIDTH cycles while in_ready
//   is held low.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   issue handshake (transfer when both high)
//   ctrl                  4-bit operation code
//   operand1, operand2    source operands a, b
//   kill                  abort of an in-flight MULU/DIVU (ignored in IDLE)
//   out_valid             one-cycle pulse: result fields updated
//   result, hi            primary result / product high or remainder
//   cout, ovf, zero, dz, illegal   status flags, held with the result
// ---------------------------------------------------------------------------
module exec_alu_md #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             kill,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             dz,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_MULU = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // product high / partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;       // multiplier / dividend->quotient
  logic [WIDTH-1:0] opb_q, opb_d;     // multiplicand / divisor
  logic             is_div_q, is_div_d;
  logic             zpend_q, zpend_d; // a == b of the iterative op

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             dz_q, dz_d;
  logic             illegal_q, illegal_d;

  // -------------------------------------------------------------------------
  // Single-cycle ALU
  // -------------------------------------------------------------------------
  logic [WIDTH:0]   add_sum, sub_dif;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_ovf, alu_ill;
  logic [SW-1:0]    shamt;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    alu_ill  = 1'b0;
    shamt    = operand2[SW-1:0];
    add_sum  = {1'b0, operand1} + {1'b0, operand2};
    sub_dif  = {1'b0, operand1} - {1'b0, operand2};
    case (ctrl)
      OP_AND:  alu_res = operand1 & operand2;
      OP_OR:   alu_res = operand1 | operand2;
      OP_XOR:  alu_res = operand1 ^ operand2;
      OP_NOR:  alu_res = ~(operand1 | operand2);
      OP_ADD: begin
        alu_res  = add_sum[WIDTH-1:0];
        alu_cout = add_sum[WIDTH];
        alu_ovf  = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res  = sub_dif[WIDTH-1:0];
        alu_cout = sub_dif[WIDTH];    // borrow out: a < b unsigned
        alu_ovf  = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                   (sub_dif[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SLL:  alu_res = operand1 << shamt;
      OP_SRL:  alu_res = operand1 >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(operand1) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(operand1) < $signed(operand2)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, operand1 < operand2};
      OP_MULU, OP_DIVU: alu_res = '0;  // handled by the iterative path
      default: alu_ill = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // One multiply / divide iteration
  // -------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] step_acc, step_sh;

  always_comb begin
    // Shift-add: add multiplicand when the multiplier LSB is set, then shift
    // the {acc, multiplier} pair right with the carry entering at the top.
    mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
    // Restoring divide: bring in the next dividend bit, keep the difference
    // when it does not borrow. With b = 0 every step succeeds, which yields
    // quotient all ones and remainder a without a special case.
    div_shift = {acc_q, sh_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ok    = ~div_diff[WIDTH];
    if (is_div_q) begin
      step_acc = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_sh  = {sh_q[WIDTH-2:0], div_ok};
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and datapath/output next values
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sh_d        = sh_q;
    opb_d       = opb_q;
    is_div_d    = is_div_q;
    zpend_d     = zpend_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    hi_d        = hi_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    dz_d        = dz_q;
    illegal_d   = illegal_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (ctrl == OP_MULU || ctrl == OP_DIVU) begin
            acc_d    = '0;
            sh_d     = operand1;
            opb_d    = operand2;
            is_div_d = (ctrl == OP_DIVU);
            zpend_d  = (operand1 == operand2);
            cnt_d    = CW'(WIDTH - 1);
            state_d  = S_BUSY;
          end else begin
            result_d    = alu_res;
            hi_d        = '0;
            cout_d      = alu_cout;
            ovf_d       = alu_ovf;
            zero_d      = (operand1 == operand2);
            dz_d        = 1'b0;
            illegal_d   = alu_ill;
            out_valid_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (kill) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          acc_d = step_acc;
          sh_d  = step_sh;
          if (cnt_q == '0) begin
            result_d    = step_sh;
            hi_d        = step_acc;
            cout_d      = 1'b0;
            ovf_d       = 1'b0;
            zero_d      = zpend_q;
            dz_d        = is_div_q && (opb_q == '0);
            illegal_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values of the previous cycle regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the operand/accumulator registers are reset along with the outputs;
  // they are few and resetting them keeps the unit deterministic after a
  // mid-operation reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      sh_q        <= '0;
      opb_q       <= '0;
      is_div_q    <= 1'b0;
      zpend_q     <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      hi_q        <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      dz_q        <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sh_q        <= sh_d;
      opb_q       <= opb_d;
      is_div_q    <= is_div_d;
      zpend_q     <= zpend_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      dz_q        <= dz_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign hi        = hi_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign dz        = dz_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/exec_alu_md.md
# exec_alu_md

Parametrised execute-stage arithmetic unit for the MIPS datapath, superseding the combinational ALU. Single-cycle logic, add/sub, shift and compare operations return a registered result one cycle after issue. Unsigned multiply and divide run iteratively over WIDTH cycles behind a valid/ready handshake. The unit sits between ID/EX operand latches and the EX/MEM register; the pipeline stalls on `in_ready` low.

## Interface
- `WIDTH`, 32: operand/result width; ≥ 4, power of two
- `CW`, $clog2(WIDTH+1): iteration counter width (internal)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operation offered
- `in_ready`  out  1  unit can accept; transfer when `in_valid && in_ready`
- `ctrl`  in  4  operation code
- `operand1`, `operand2`  in  WIDTH  source operands (a, b)
- `kill`  in  1  synchronous abort of in-flight multiply/divide
- `out_valid`  out  1  one-cycle pulse: result fields updated
- `result`  out  WIDTH  primary result (product low / quotient)
- `hi`  out  WIDTH  product high / remainder; 0 for other ops
- `cout`  out  1  carry (ADD) / borrow (SUB), else 0
- `ovf`  out  1  signed overflow (ADD/SUB), else 0
- `zero`  out  1  `operand1 == operand2` of the issued op
- `dz`  out  1  divide by zero (DIVU with b = 0)
- `illegal`  out  1  reserved ctrl code issued

## Operation
- ctrl codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 0111 SLT (signed), 0011 XOR, 0100 SLL, 0101 SRL, 1101 SRA, 1000 SLTU, 1001 MULU, 1010 DIVU; all others reserved.
- ADD: {cout,result} = {0,a}+{0,b}; ovf = sign(a)==sign(b) && sign(result)!=sign(a).
- SUB: {cout,result} = {0,a}-{0,b} (cout=1 iff a<b unsigned); ovf = sign(a)!=sign(b) && sign(result)!=sign(a).
- Shifts: amount = b[$clog2(WIDTH)-1:0]; SRA replicates a[WIDTH-1].
- SLT/SLTU: result = 1 or 0, zero-extended.
- MULU: {hi,result} = a*b, 2·WIDTH-bit product, shift-add, one bit per cycle.
- DIVU: restoring, one quotient bit per cycle; result = a/b, hi = a%b. b=0: result = all ones, hi = a, dz=1, still takes full latency.
- Reserved code: result=hi=0, illegal=1, single-cycle timing.
- Flags not listed for an op are 0. All outputs hold between `out_valid` pulses.
- FSM: IDLE, BUSY.
  - IDLE: `in_ready`=1. Accept of a single-cycle op registers all outputs, pulses `out_valid`, stays IDLE.
  - IDLE, accept of MULU/DIVU: latch operands, zero accumulator, counter ← WIDTH-1, go BUSY.
  - BUSY: `in_ready`=0, one iteration per cycle. cnt≠0: decrement. cnt=0: write result/hi/flags, pulse `out_valid`, go IDLE.
- `kill` in BUSY: return to IDLE next edge; no `out_valid`; outputs keep previous values. `kill` in IDLE is ignored; it does not block a same-cycle accept.
- `in_valid` while BUSY is ignored; the upstream holds it.

## Timing
- Reset (async assert, sync-safe release): state IDLE, counter 0, `out_valid`=0, `result`=`hi`=0, `cout`=`ovf`=`zero`=`dz`=`illegal`=0, `in_ready`=1 once reset deasserts.
- Single-cycle op accepted in cycle N: `out_valid` high in cycle N+1. Back-to-back issue every cycle is supported.
- MULU/DIVU accepted in cycle N: BUSY in cycles N+1..N+WIDTH, `out_valid` and `in_ready` high in cycle N+WIDTH+1. A new op may be accepted in that cycle.
- Kill asserted in BUSY cycle M: IDLE (`in_ready`=1) in cycle M+1.
- Reset mid-BUSY: immediate return to reset state; the operation is lost.

## Test plan
- Reset: assert `rst_n`=0 mid-DIVU → all outputs 0, `in_ready`=1 after release, no `out_valid`.
- Single-cycle ops (WIDTH=32), back-to-back: ADD 0xFFFFFFFF+1 → result 0, cout 1, ovf 0. ADD 0x7FFFFFFF+1 → 0x80000000, ovf 1. SUB 3-5 → 0xFFFFFFFE, cout 1. SLT 0xFFFFFFFF,1 → 1. SLTU 0xFFFFFFFF,1 → 0. SRA 0x80000000 by 4 → 0xF8000000. `out_valid` each following cycle.
- MULU 0xFFFFFFFF × 0xFFFFFFFF → hi 0xFFFFFFFE, result 0x00000001. `out_valid` exactly 33 cycles after accept; `in_ready` low cycles 1..32.
- DIVU 100/7 → result 14, hi 2. DIVU 5/0 → result 0xFFFFFFFF, hi 5, dz 1, same latency.
- Kill: DIVU issued, `kill` at BUSY cycle 10 → IDLE next cycle, no `out_valid`, prior result retained. Immediate ADD 2+2 → 4 one cycle later.
- Reserved ctrl 1111 → result 0, illegal 1, `out_valid` next cycle. `zero`=1 when a==b for any op.
